// File: rtl/dpram_pipe.sv
// dpram_pipe: single-clock true dual-port RAM with registered reads and
// per-port illegal/collision flags. Define DPRAM_OUTREG_EN for an extra output stage (LAT=2).

module dpram_port_out #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              ill,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] dout,
  output logic              val,
  output logic              err
);
  logic [STAGES:1]             vld_pipe;
  logic [STAGES:1]             err_pipe;
  logic [STAGES:1][DATA_W-1:0] dat_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd;
      err_pipe[1] <= ill;
      // first stage holds on idle; later stages just copy, so the hold propagates
      if (rd)       dat_pipe[1] <= rdata;
      else if (ill) dat_pipe[1] <= '0;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        err_pipe[s] <= err_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign dout = dat_pipe[STAGES];
  assign val  = vld_pipe[STAGES];
  assign err  = err_pipe[STAGES];
endmodule

module dpram_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wea,
  input  logic              rea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dia,
  output logic [DATA_W-1:0] doa,
  output logic              vala,
  output logic              erra,
  input  logic              web,
  input  logic              reb,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dib,
  output logic [DATA_W-1:0] dob,
  output logic              valb,
  output logic              errb,
  output logic              coll
);
`ifdef DPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]            mem [DEPTH];
  logic [1:0]                   we, re, rd, ill, wr, val, err;
  logic [1:0][ADDR_W-1:0]       addr;
  logic [1:0][DATA_W-1:0]       di, rdata, dout;
  logic                         coll_now;
  logic [LAT:1]                 coll_pipe;

  assign we   = {web, wea};
  assign re   = {reb, rea};
  assign addr = {addrb, addra};
  assign di   = {dib, dia};
  assign rd   = re & ~we;
  assign ill  = re & we;
  assign wr   = we & ~re & ~{2{rst}};
  assign coll_now = wr[0] & wr[1] & (addr[0] == addr[1]);

  // port A wins a same-address write; reads see pre-write data via NBA ordering
  always_ff @(posedge clk) begin
    if (wr[0])              mem[addr[0]] <= di[0];
    if (wr[1] && !coll_now) mem[addr[1]] <= di[1];
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign rdata[p] = mem[addr[p]];
    dpram_port_out #(.DATA_W(DATA_W), .STAGES(LAT)) u_out (
      .clk  (clk),
      .rst  (rst),
      .rd   (rd[p]),
      .ill  (ill[p]),
      .rdata(rdata[p]),
      .dout (dout[p]),
      .val  (val[p]),
      .err  (err[p])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coll_pipe <= '0;
    else begin
      coll_pipe[1] <= coll_now;
      for (int s = 2; s <= LAT; s++) coll_pipe[s] <= coll_pipe[s-1];
    end
  end

  assign doa  = dout[0];
  assign dob  = dout[1];
  assign vala = val[0];
  assign valb = val[1];
  assign erra = err[0];
  assign errb = err[1];
  assign coll = coll_pipe[LAT];
endmodule

// File: tb/tb_dpram_pipe.sv
// Directed bench for dpram_pipe: 8x256 instance for the functional cases,
// 16x16 instance for dual-port streaming. Latency follows DPRAM_OUTREG_EN.
module tb_dpram_pipe;
`ifdef DPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic       wea, rea, web, reb, vala, erra, valb, errb, coll;
  logic [7:0] addra, addrb, dia, dib, doa, dob;

  logic        s_wea, s_rea, s_web, s_reb, s_vala, s_erra, s_valb, s_errb, s_coll;
  logic [3:0]  s_addra, s_addrb;
  logic [15:0] s_dia, s_dib, s_doa, s_dob;

  int tests = 0, fails = 0;

  dpram_pipe u_dut (
    .clk(clk), .rst(rst),
    .wea(wea), .rea(rea), .addra(addra), .dia(dia), .doa(doa), .vala(vala), .erra(erra),
    .web(web), .reb(reb), .addrb(addrb), .dib(dib), .dob(dob), .valb(valb), .errb(errb),
    .coll(coll)
  );

  dpram_pipe #(.DATA_W(16), .ADDR_W(4)) u_dut16 (
    .clk(clk), .rst(rst),
    .wea(s_wea), .rea(s_rea), .addra(s_addra), .dia(s_dia), .doa(s_doa), .vala(s_vala), .erra(s_erra),
    .web(s_web), .reb(s_reb), .addrb(s_addrb), .dib(s_dib), .dob(s_dob), .valb(s_valb), .errb(s_errb),
    .coll(s_coll)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wea = 0; rea = 0; web = 0; reb = 0; addra = 0; addrb = 0; dia = 0; dib = 0;
    s_wea = 0; s_rea = 0; s_web = 0; s_reb = 0; s_addra = 0; s_addrb = 0; s_dia = 0; s_dib = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    step();
    tests++; if ({doa, dob} !== 16'h0) begin fails++; $display("FAIL reset_data doa=%h dob=%h want 0", doa, dob); end
    tests++; if ({vala, valb, erra, errb, coll} !== 5'b0) begin fails++; $display("FAIL reset_flags got %b want 00000", {vala, valb, erra, errb, coll}); end
    tests++; if ({s_doa, s_dob, s_vala, s_valb, s_coll} !== 35'h0) begin fails++; $display("FAIL reset_dut16 got %h want 0", {s_doa, s_dob, s_vala, s_valb, s_coll}); end
    rst = 0;
  endtask

  task automatic test_write_read();
    wea = 1; addra = 8'h10; dia = 8'hA5;
    step(); idle();
    reb = 1; addrb = 8'h10;
    step(); idle();
    for (int k = 1; k < LAT; k++) begin
      tests++; if (valb !== 1'b0) begin fails++; $display("FAIL wr_rd_early k=%0d valb=%b want 0", k, valb); end
      step();
    end
    tests++; if (valb !== 1'b1 || dob !== 8'hA5) begin fails++; $display("FAIL wr_rd valb=%b dob=%h want 1/a5", valb, dob); end
    step();
    tests++; if (valb !== 1'b0 || dob !== 8'hA5) begin fails++; $display("FAIL wr_rd_hold valb=%b dob=%h want 0/a5", valb, dob); end
  endtask

  task automatic test_ww_coll();
    wea = 1; addra = 8'h20; dia = 8'h11;
    web = 1; addrb = 8'h20; dib = 8'h22;
    step(); idle();
    for (int k = 1; k < LAT; k++) begin
      tests++; if (coll !== 1'b0) begin fails++; $display("FAIL coll_early coll=%b want 0", coll); end
      step();
    end
    tests++; if (coll !== 1'b1) begin fails++; $display("FAIL coll_pulse coll=%b want 1", coll); end
    step();
    tests++; if (coll !== 1'b0) begin fails++; $display("FAIL coll_single coll=%b want 0", coll); end
    rea = 1; addra = 8'h20;
    step(); idle();
    repeat (LAT-1) step();
    tests++; if (vala !== 1'b1 || doa !== 8'h11) begin fails++; $display("FAIL coll_data vala=%b doa=%h want 1/11", vala, doa); end
  endtask

  task automatic test_rw_same();
    wea = 1; addra = 8'h30; dia = 8'h55;
    step(); idle();
    wea = 1; addra = 8'h30; dia = 8'h77;
    reb = 1; addrb = 8'h30;
    step(); idle();
    repeat (LAT-1) step();
    tests++; if (valb !== 1'b1 || dob !== 8'h55 || coll !== 1'b0) begin fails++; $display("FAIL rw_old valb=%b dob=%h coll=%b want 1/55/0", valb, dob, coll); end
    reb = 1; addrb = 8'h30;
    step(); idle();
    repeat (LAT-1) step();
    tests++; if (valb !== 1'b1 || dob !== 8'h77) begin fails++; $display("FAIL rw_new valb=%b dob=%h want 1/77", valb, dob); end
  endtask

  task automatic test_illegal();
    wea = 1; addra = 8'h40; dia = 8'h3C;
    step(); idle();
    rea = 1; addra = 8'h40;
    step(); idle();
    repeat (LAT-1) step();
    tests++; if (doa !== 8'h3C) begin fails++; $display("FAIL ill_pre doa=%h want 3c", doa); end
    wea = 1; rea = 1; addra = 8'h40; dia = 8'hFF;
    step(); idle();
    repeat (LAT-1) step();
    tests++; if (erra !== 1'b1 || vala !== 1'b0 || doa !== 8'h00) begin fails++; $display("FAIL ill_pulse erra=%b vala=%b doa=%h want 1/0/00", erra, vala, doa); end
    step();
    tests++; if (erra !== 1'b0 || doa !== 8'h00) begin fails++; $display("FAIL ill_after erra=%b doa=%h want 0/00", erra, doa); end
    rea = 1; addra = 8'h40;
    step(); idle();
    repeat (LAT-1) step();
    tests++; if (vala !== 1'b1 || doa !== 8'h3C) begin fails++; $display("FAIL ill_nowrite vala=%b doa=%h want 1/3c", vala, doa); end
  endtask

  task automatic test_reset_inflight();
    int seen = 0;
    rea = 1; addra = 8'h10;
    step(); idle();
    #2 rst = 1;
    #1;
    tests++; if (doa !== 8'h00 || vala !== 1'b0) begin fails++; $display("FAIL rst_async doa=%h vala=%b want 00/0", doa, vala); end
    step(); step();
    rst = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      step();
      if (vala === 1'b1) seen++;
    end
    tests++; if (seen != 0 || doa !== 8'h00) begin fails++; $display("FAIL rst_no_val pulses=%0d doa=%h want 0/00", seen, doa); end
    rea = 1; addra = 8'h10;
    step(); idle();
    repeat (LAT-1) step();
    tests++; if (vala !== 1'b1 || doa !== 8'hA5) begin fails++; $display("FAIL rst_mem_kept vala=%b doa=%h want 1/a5", vala, doa); end
  endtask

  task automatic test_stream();
    int pa = 0, pb = 0, bad = 0;
    logic [15:0] ea, eb;
    // A fills 0..7 while B fills 8..15 in the same cycles
    for (int i = 0; i < 8; i++) begin
      s_wea = 1; s_addra = 4'(i);     s_dia = 16'(32'h1111 * i);
      s_web = 1; s_addrb = 4'(i + 8); s_dib = 16'(32'h1111 * (i + 8));
      step();
    end
    idle();
    for (int c = 0; c < 16 + LAT - 1; c++) begin
      if (c < 16) begin
        s_rea = 1; s_addra = 4'(c);
        s_reb = 1; s_addrb = 4'(15 - c);
      end else idle();
      step();
      if (c - LAT + 1 >= 0) begin
        ea = 16'(32'h1111 * (c - LAT + 1));
        eb = 16'(32'h1111 * (15 - (c - LAT + 1)));
        if (s_vala === 1'b1) pa++;
        if (s_valb === 1'b1) pb++;
        if (s_vala !== 1'b1 || s_doa !== ea || s_valb !== 1'b1 || s_dob !== eb) begin
          bad++;
          $display("FAIL stream_beat j=%0d a=%b/%h b=%b/%h want 1/%h 1/%h", c - LAT + 1, s_vala, s_doa, s_valb, s_dob, ea, eb);
        end
      end
    end
    idle();
    step();
    tests++; if (bad != 0) begin fails++; $display("FAIL stream_data bad_beats=%0d want 0", bad); end
    tests++; if (pa != 16 || pb != 16) begin fails++; $display("FAIL stream_count a=%0d b=%0d want 16/16", pa, pb); end
    tests++; if (s_vala !== 1'b0 || s_valb !== 1'b0 || s_coll !== 1'b0) begin fails++; $display("FAIL stream_end vala=%b valb=%b coll=%b want 0", s_vala, s_valb, s_coll); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_ww_coll();
    test_rw_same();
    test_illegal();
    test_reset_inflight();
    test_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
